// File: rtl/data_mem_be.sv
// Byte-enabled word memory with a registered read port, address checking and a
// trigger-word driven dump of the low words onto TestPort.
module data_mem_be #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DUMP_WORDS = 8,
  parameter int unsigned TRIG_IDX   = 100,
  parameter int unsigned TRIG_VAL   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ReadMem,
  input  logic                WriteMem,
  input  logic [31:0]         Addr,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic [DATA_W-1:0]   Data_i,
  output logic [DATA_W-1:0]   Data,
  output logic                DataValid,
  output logic                AddrErr,
  output logic [DATA_W-1:0]   TestPort,
  output logic                TestValid,
  output logic                DumpDone
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW-1:0]     TRIG_ADDR = AW'(TRIG_IDX);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(DUMP_WORDS - 1);
  localparam logic [DATA_W-1:0] TRIG_WORD = DATA_W'(TRIG_VAL);

  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : gen_bad_width
    $error("data_mem_be: DATA_W must be a non-zero multiple of 8");
  end
  if (DUMP_WORDS == 0 || DUMP_WORDS > DEPTH || TRIG_IDX >= DEPTH) begin : gen_bad_dump
    $error("data_mem_be: dump window or trigger word outside the memory");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic          access;
  logic          in_range;
  logic          illegal;
  logic          wr_en;
  logic [AW-1:0] word_idx;

  assign access   = ReadMem | WriteMem;
  assign in_range = ({2'b00, Addr[31:2]} < DEPTH);
  assign illegal  = access & ((Addr[1:0] != 2'b00) | ~in_range);
  assign wr_en    = WriteMem & ~illegal;
  assign word_idx = Addr[AW+1:2];

  // Memory array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (ByteEn[b]) begin
          mem[word_idx][8*b +: 8] <= Data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data      <= '0;
      DataValid <= 1'b0;
      AddrErr   <= 1'b0;
    end else begin
      AddrErr   <= illegal;
      DataValid <= ReadMem;
      if (ReadMem) begin
        Data <= illegal ? '0 : mem[word_idx];
      end
    end
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] cnt_addr;
  logic          trig;

  assign cnt_addr = AW'(cnt);
  assign trig     = (mem[TRIG_ADDR] == TRIG_WORD);

  // Nonblocking memory writes mean a word written while dumped shows its old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      TestPort  <= '0;
      TestValid <= 1'b0;
      DumpDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TestValid <= 1'b0;
          DumpDone  <= 1'b0;
          if (trig) begin
            state <= DUMP;
            cnt   <= '0;
          end
        end
        DUMP: begin
          TestPort  <= mem[cnt_addr];
          TestValid <= 1'b1;
          DumpDone  <= 1'b0;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          TestValid <= 1'b0;
          if (trig) begin
            DumpDone <= 1'b1;
          end else begin
            DumpDone <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          TestValid <= 1'b0;
          DumpDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be: a word/byte-level memory model predicts every
// output each cycle, with literal expectations pinning the key scenarios.
module tb_data_mem_be;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NW    = 8;
  localparam int unsigned TI    = 100;
  localparam logic [31:0] TV    = 32'd9;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic        rd, wr;
  logic [31:0] addr, din;
  logic [3:0]  be;
  logic [31:0] data, test_port;
  logic        data_valid, addr_err, test_valid, dump_done;

  logic        rd2, wr2;
  logic [31:0] addr2;
  logic [7:0]  be2;
  logic [63:0] din2, data2, tp2;
  logic        dv2, ae2, tv2, dd2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_data, e_tp;
  logic        e_dv, e_err, e_tv, e_done;
  int          since;

  always #5 clk = ~clk;

  data_mem_be u_dut (
    .clk(clk), .rst_n(rst_n), .ReadMem(rd), .WriteMem(wr), .Addr(addr), .ByteEn(be),
    .Data_i(din), .Data(data), .DataValid(data_valid), .AddrErr(addr_err),
    .TestPort(test_port), .TestValid(test_valid), .DumpDone(dump_done)
  );

  data_mem_be #(
    .DATA_W(64), .DEPTH(16), .DUMP_WORDS(4), .TRIG_IDX(10), .TRIG_VAL(9)
  ) u_dut64 (
    .clk(clk), .rst_n(rst_n), .ReadMem(rd2), .WriteMem(wr2), .Addr(addr2), .ByteEn(be2),
    .Data_i(din2), .Data(data2), .DataValid(dv2), .AddrErr(ae2),
    .TestPort(tp2), .TestValid(tv2), .DumpDone(dd2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    e_data = '0; e_dv = 1'b0; e_err = 1'b0;
    e_tp = '0;   e_tv = 1'b0; e_done = 1'b0;
    since = -1;
  endtask

  // since: -1 idle, 0..NW-1 next word to stream, NW finished
  task automatic model_edge();
    logic        bad, trig;
    int          w;
    logic [31:0] mask;
    bad = (rd || wr) && (addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= DEPTH);
    w   = int'(addr[31:2]);
    if (!rst_n) begin
      model_reset();
    end else begin
      e_err = bad;
      e_dv  = rd;
      if (rd) e_data = bad ? 32'h0 : m_mem[w];
      trig = (m_mem[TI] == TV);
      if (since < 0) begin
        e_tv = 1'b0; e_done = 1'b0;
        if (trig) since = 0;
      end else if (since < int'(NW)) begin
        e_tp = m_mem[since];
        e_tv = 1'b1;
        since++;
      end else begin
        e_tv   = 1'b0;
        e_done = trig;
        if (!trig) since = -1;
      end
    end
    if (wr && !bad) begin
      mask = '0;
      for (int b = 0; b < 4; b++) if (be[b]) mask |= 32'hFF << (8 * b);
      m_mem[w] = (m_mem[w] & ~mask) | (din & mask);
    end
  endtask

  task automatic check_cycle();
    chk("Data", data, e_data);
    chk("DataValid", data_valid, e_dv);
    chk("AddrErr", addr_err, e_err);
    chk("TestPort", test_port, e_tp);
    chk("TestValid", test_valid, e_tv);
    chk("DumpDone", dump_done, e_done);
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    rd = r; wr = w; addr = a; be = b; din = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, a, b, d);
  endtask

  task automatic rd_word(input logic [31:0] a);
    step(1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic step2(input logic r, input logic w, input logic [31:0] a,
                       input logic [7:0] b, input logic [63:0] d);
    rd2 = r; wr2 = w; addr2 = a; be2 = b; din2 = d;
    idle();
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  initial begin
    rd = 1'b0; wr = 1'b0; addr = '0; be = '0; din = '0;
    rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; be2 = '0; din2 = '0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    chk("reset_Data", data, 32'h0);
    chk("reset_DataValid", data_valid, 1'b0);
    chk("reset_TestValid", test_valid, 1'b0);
    chk("reset_DumpDone", dump_done, 1'b0);

    // Define the trigger words while still in reset.
    wr_word(TI * 4, 32'h0, 4'hF);
    step2(1'b0, 1'b1, 32'h28, 8'hFF, 64'h0);
    rst_n = 1'b1;
    idle();

    // Byte-enable merge and read latency.
    wr_word(32'h10, 32'hA5A5A5A5, 4'hF);
    wr_word(32'h10, 32'h000000FF, 4'h1);
    rd_word(32'h10);
    chk("be_merge_data", data, 32'hA5A5A5FF);
    chk("be_merge_valid", data_valid, 1'b1);
    idle();
    chk("valid_drops", data_valid, 1'b0);
    chk("data_holds", data, 32'hA5A5A5FF);

    // All-zero ByteEn is a legal no-op.
    wr_word(32'h10, 32'h0, 4'h0);
    chk("be0_no_err", addr_err, 1'b0);

    // Illegal accesses.
    rd_word(32'h13);
    chk("misalign_err", addr_err, 1'b1);
    chk("misalign_data", data, 32'h0);
    rd_word(DEPTH * 4);
    chk("range_err", addr_err, 1'b1);
    chk("range_valid", data_valid, 1'b1);
    wr_word(32'h12, 32'h0, 4'hF);
    chk("bad_wr_err", addr_err, 1'b1);
    chk("bad_wr_no_valid", data_valid, 1'b0);
    rd_word(32'h10);
    chk("bad_wr_kept", data, 32'hA5A5A5FF);
    chk("legal_clears_err", addr_err, 1'b0);
    wr_word((DEPTH - 1) * 4, 32'hDEADBEEF, 4'hF);
    rd_word((DEPTH - 1) * 4);
    chk("last_word", data, 32'hDEADBEEF);

    // Read-during-write returns the old word.
    wr_word(32'h20, 32'h11, 4'hF);
    step(1'b1, 1'b1, 32'h20, 4'hF, 32'h55);
    chk("rdw_old", data, 32'h11);
    rd_word(32'h20);
    chk("rdw_new", data, 32'h55);

    // Dump of words 0..7.
    for (int i = 0; i < int'(NW); i++) wr_word(i * 4, 32'(10 + i), 4'hF);
    wr_word(TI * 4, TV, 4'hF);
    idle();
    chk("dump_start_tv", test_valid, 1'b0);
    for (int k = 0; k < int'(NW); k++) begin
      idle();
      chk("dump_tv", test_valid, 1'b1);
      chk("dump_word", test_port, 32'(10 + k));
    end
    idle();
    chk("dump_done_tv", test_valid, 1'b0);
    chk("dump_done", dump_done, 1'b1);
    wr_word(TI * 4, 32'h0, 4'hF);
    idle();
    chk("done_clear", dump_done, 1'b0);
    chk("tp_holds", test_port, 32'd17);
    idle();
    chk("back_idle", test_valid, 1'b0);

    // Reset during the 4th dump word, then restart from word 0.
    wr_word(TI * 4, TV, 4'hF);
    for (int k = 0; k < 5; k++) idle();
    chk("fourth_word", test_port, 32'd13);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_tp", test_port, 32'h0);
    chk("mid_rst_tv", test_valid, 1'b0);
    chk("mid_rst_dd", dump_done, 1'b0);
    chk("mid_rst_data", data, 32'h0);
    chk("mid_rst_err", addr_err, 1'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    idle();
    chk("restart_tv0", test_valid, 1'b0);
    wr_word(32'h0, 32'd99, 4'hF);
    chk("restart_w0_old", test_port, 32'd10);
    chk("restart_tv", test_valid, 1'b1);
    idle();
    chk("restart_w1", test_port, 32'd11);
    for (int k = 0; k < int'(NW); k++) idle();
    chk("restart_done", dump_done, 1'b1);
    wr_word(TI * 4, 32'h0, 4'hF);
    idle();
    idle();

    // 64-bit, 16-word instance.
    step2(1'b0, 1'b1, 32'h8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step2(1'b0, 1'b1, 32'h8, 8'h0F, 64'h1122_3344_5566_7788);
    step2(1'b1, 1'b0, 32'h8, 8'h00, 64'h0);
    chk("w64_low_only", data2, 64'hFFFF_FFFF_5566_7788);
    chk("w64_valid", dv2, 1'b1);
    step2(1'b1, 1'b0, 32'h3C, 8'h00, 64'h0);
    chk("w64_last_ok", ae2, 1'b0);
    step2(1'b1, 1'b0, 32'h40, 8'h00, 64'h0);
    chk("w64_range_err", ae2, 1'b1);
    chk("w64_range_data", data2, 64'h0);
    for (int k = 0; k < 8; k++) idle();
    chk("w64_no_dump", tv2, 1'b0);
    chk("w64_no_done", dd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of words.
REQ-003 Parameter DUMP_WORDS, default 8, number of words streamed on TestPort per dump.
REQ-004 Parameter TRIG_IDX, default 100, word index of the dump-trigger word.
REQ-005 Parameter TRIG_VAL, default 9, trigger value.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 ReadMem  in  1  read request.
REQ-009 WriteMem  in  1  write request.
REQ-010 Addr  in  32  byte address; word index = Addr[31:2].
REQ-011 ByteEn  in  DATA_W/8  per-byte write enable; bit k covers Data_i[8k+7:8k].
REQ-012 Data_i  in  DATA_W  write data.
REQ-013 Data  out  DATA_W  registered read data.
REQ-014 DataValid  out  1  Data carries the result of the previous cycle's read.
REQ-015 AddrErr  out  1  registered error flag for the previous cycle's access.
REQ-016 TestPort  out  DATA_W  dump data.
REQ-017 TestValid  out  1  TestPort carries a dump word this cycle.
REQ-018 DumpDone  out  1  dump complete.

Function
REQ-019 An access SHALL be illegal when ReadMem or WriteMem is high and either Addr[1:0]!=0 or Addr[31:2]>=DEPTH.
REQ-020 An illegal access SHALL set AddrErr=1 on the next cycle, suppress the write, and return Data=0 with DataValid=1 if ReadMem was high.
REQ-021 A legal write SHALL update only the bytes with ByteEn=1; ByteEn=0 for all bytes SHALL be a no-op and SHALL NOT raise AddrErr.
REQ-022 A read SHALL have 1-cycle latency: ReadMem sampled at edge N -> Data and DataValid=1 valid after edge N, cleared after edge N+1 unless ReadMem is high again.
REQ-023 Without a read, Data SHALL hold its last value; Data SHALL never be driven to Z.
REQ-024 Simultaneous read and write to the same word SHALL return the old (pre-write) contents.
REQ-025 AddrErr SHALL be 0 on any cycle following a legal access or no access.
REQ-026 The dump FSM SHALL have states IDLE, DUMP and DONE.
REQ-027 IDLE->DUMP SHALL occur when Mem[TRIG_IDX]==TRIG_VAL; the counter SHALL be set to 0.
REQ-028 In DUMP, each cycle SHALL register TestPort<=Mem[cnt] and TestValid<=1, then increment cnt; after cnt==DUMP_WORDS-1 the FSM SHALL go to DONE.
REQ-029 In DONE, the FSM SHALL set DumpDone=1 and TestValid=0, and SHALL hold until Mem[TRIG_IDX]!=TRIG_VAL, then return to IDLE with DumpDone=0.
REQ-030 A write to word cnt in the same cycle it is dumped SHALL yield the old value on TestPort.
REQ-031 cnt width SHALL be clog2(DUMP_WORDS) with a minimum of 1, and SHALL NOT wrap inside a dump.
REQ-032 When DUMP_WORDS>DEPTH or TRIG_IDX>=DEPTH, elaboration SHALL fail.
REQ-033 TestPort SHALL hold its last dumped word in IDLE and DONE.

Reset
REQ-034 rst_n=0 SHALL immediately force Data=0, DataValid=0, AddrErr=0, TestPort=0, TestValid=0, DumpDone=0, FSM=IDLE and cnt=0.
REQ-035 Memory contents SHALL NOT be affected by reset.
REQ-036 Reset asserted mid-dump SHALL abort the dump; after release, a still-valid trigger SHALL restart the dump from cnt=0.

Verification
REQ-037 Write 0xA5A5A5A5 with ByteEn=1111 to Addr 0x10, then 0x000000FF with ByteEn=0001, then read Addr 0x10 -> Data=0xA5A5A5FF and DataValid=1 exactly one cycle after the read.
REQ-038 Read Addr 0x13 and read Addr 4*DEPTH -> AddrErr=1 and Data=0 for each; a write to Addr 0x12 leaves the target word unchanged.
REQ-039 Same-cycle read and write of 0x55 to Addr 0x20 holding 0x11 -> Data=0x11; a following read -> 0x55.
REQ-040 Preload words 0..7 with 10..17, then write 9 to word 100 -> TestValid high for 8 consecutive cycles with TestPort=10..17, then DumpDone=1; write 0 to word 100 -> DumpDone=0 and FSM=IDLE.
REQ-041 Pulse rst_n low during the 4th dump word -> all outputs 0 immediately; after release the dump restarts at word 0.
REQ-042 Run with DATA_W=64 and DEPTH=16, writing with ByteEn=0x0F -> only the low 32 bits are updated; Addr 0x40 -> AddrErr=1.
